// File: rtl/fios_opsrv_pkg.sv
// Shared types and constants for the FIOS operand server.
package fios_opsrv_pkg;

    localparam int WORD_W = 17;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_P = 2'd2;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/fios_word_ram.sv
// DEPTH x WORD_W register array: one write port, one registered read port.
// The read register is write-first so a same-cycle write to the read address is seen.
module fios_word_ram
    import fios_opsrv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // NOTE: the array has no reset on purpose; only the read register is reset.
    always_ff @(posedge clock_i) begin
        if (we_i)
            r_mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            r_rdata <= '0;
        else if (re_i)
            r_rdata <= (we_i && (waddr_i == raddr_i)) ? wdata_i : r_mem[raddr_i];
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/fios_operand_server.sv
// Host-loaded operand/result buffer serving the FIOS multiplier.
// Optional RUN-cycle counter output cycles_o when FIOS_OPSRV_PERF_EN is defined.
module fios_operand_server
    import fios_opsrv_pkg::*;
#(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [1:0]                load_sel_i,
    input  logic [WORD_W-1:0]         load_data_i,
    input  logic                      go_i,
    output logic                      start_o,
    output logic [PE_NB*WORD_W-1:0]   a_o,
    input  logic                      a_shift_i,
    output logic [WORD_W-1:0]         b_o,
    input  logic                      b_fetch_i,
    output logic [WORD_W-1:0]         p_o,
    input  logic                      p_fetch_i,
    input  logic [WORD_W-1:0]         res_i,
    input  logic                      res_push_i,
    input  logic                      done_i,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [WORD_W-1:0]         rd_data_o,
    output logic                      err_o
`ifdef FIOS_OPSRV_PERF_EN
    ,
    output logic [31:0]               cycles_o
`endif
);

    localparam int AGRP  = (s + PE_NB - 1) / PE_NB;
    localparam int GW    = (AGRP > 1) ? $clog2(AGRP) : 1;
    localparam int AW    = (s > 1) ? $clog2(s) : 1;
    localparam int CNT_W = $clog2(s + 1);

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt_a, r_cnt_b, r_cnt_p, r_res_cnt, w_sel_cnt, w_res_cnt_eff;
    logic [AW-1:0]           r_b_idx, r_p_idx, r_rd_idx;
    logic [AW-1:0]           w_b_idx_nxt, w_p_idx_nxt, w_rd_idx_nxt;
    logic [GW-1:0]           r_grp, w_grp_nxt;
    logic [WORD_W-1:0]       r_a_mem [s];
    logic [PE_NB*WORD_W-1:0] r_a_o, w_a_grp;
    logic                    r_err;
    logic w_load_acc, w_load_wr, w_load_bad, w_go_ok, w_run, w_start;
    logic w_push_ok, w_push_bad, w_done, w_short, w_rd_hs, w_rd_last;

    // ---------------- decode ----------------
    always_comb begin
        w_sel_cnt = '0;
        case (load_sel_i)
            SEL_A:   w_sel_cnt = r_cnt_a;
            SEL_B:   w_sel_cnt = r_cnt_b;
            SEL_P:   w_sel_cnt = r_cnt_p;
            default: w_sel_cnt = '0;
        endcase
    end

    assign w_load_acc = (r_state == LOAD) && load_valid_i;
    assign w_load_bad = w_load_acc && ((load_sel_i == 2'd3) || (w_sel_cnt == CNT_W'(s)));
    assign w_load_wr  = w_load_acc && !w_load_bad;
    assign w_go_ok    = (r_state == LOAD) && go_i && (r_cnt_a == CNT_W'(s))
                        && (r_cnt_b == CNT_W'(s)) && (r_cnt_p == CNT_W'(s));
    assign w_start    = (r_state == START);
    assign w_run      = (r_state == RUN);

    assign w_push_ok     = w_run && res_push_i && (r_res_cnt != CNT_W'(s));
    assign w_push_bad    = w_run && res_push_i && (r_res_cnt == CNT_W'(s));
    assign w_res_cnt_eff = r_res_cnt + CNT_W'(w_push_ok);
    assign w_done        = w_run && done_i;
    // A push in the same cycle as done counts toward the result length.
    assign w_short       = w_done && (w_res_cnt_eff != CNT_W'(s));

    assign w_rd_hs   = (r_state == DRAIN) && rd_ready_i;
    assign w_rd_last = w_rd_hs && (r_rd_idx == AW'(s - 1));

    assign w_b_idx_nxt  = (r_b_idx  == AW'(s - 1)) ? '0 : r_b_idx  + 1'b1;
    assign w_p_idx_nxt  = (r_p_idx  == AW'(s - 1)) ? '0 : r_p_idx  + 1'b1;
    assign w_rd_idx_nxt = (r_rd_idx == AW'(s - 1)) ? '0 : r_rd_idx + 1'b1;

    // Parallel A group view; words past the end of A read as zero.
    always_comb begin
        w_grp_nxt = '0;
        if (!w_start)
            w_grp_nxt = (r_grp == GW'(AGRP - 1)) ? '0 : r_grp + 1'b1;
        w_a_grp = '0;
        for (int k = 0; k < PE_NB; k++) begin
            if ((int'(w_grp_nxt) * PE_NB + k) < s)
                w_a_grp[k*WORD_W +: WORD_W] = r_a_mem[int'(w_grp_nxt) * PE_NB + k];
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            r_state <= LOAD;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        start_o      = 1'b0;
        load_ready_o = 1'b0;
        rd_valid_o   = 1'b0;
        case (r_state)
            LOAD: begin
                load_ready_o = 1'b1;
                if (w_go_ok)
                    w_state_nxt = START;
            end
            START: begin
                start_o     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (done_i)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                rd_valid_o = 1'b1;
                if (w_rd_last)
                    w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // ---------------- storage ----------------
    always_ff @(posedge clock_i) begin
        if (w_load_wr && (load_sel_i == SEL_A))
            r_a_mem[r_cnt_a[AW-1:0]] <= load_data_i;
    end

    fios_word_ram #(.DEPTH(s), .AW(AW)) u_b_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (w_load_wr && (load_sel_i == SEL_B)),
        .waddr_i (r_cnt_b[AW-1:0]),
        .wdata_i (load_data_i),
        .re_i    (w_start || (w_run && b_fetch_i)),
        .raddr_i (w_start ? '0 : w_b_idx_nxt),
        .rdata_o (b_o)
    );

    fios_word_ram #(.DEPTH(s), .AW(AW)) u_p_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (w_load_wr && (load_sel_i == SEL_P)),
        .waddr_i (r_cnt_p[AW-1:0]),
        .wdata_i (load_data_i),
        .re_i    (w_start || (w_run && p_fetch_i)),
        .raddr_i (w_start ? '0 : w_p_idx_nxt),
        .rdata_o (p_o)
    );

    fios_word_ram #(.DEPTH(s), .AW(AW)) u_r_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (w_push_ok),
        .waddr_i (r_res_cnt[AW-1:0]),
        .wdata_i (res_i),
        .re_i    (w_done || (w_rd_hs && !w_rd_last)),
        .raddr_i (w_done ? '0 : w_rd_idx_nxt),
        .rdata_o (rd_data_o)
    );

    // ---------------- counters, indexes, error ----------------
    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_cnt_p   <= '0;
            r_res_cnt <= '0;
            r_b_idx   <= '0;
            r_p_idx   <= '0;
            r_rd_idx  <= '0;
            r_grp     <= '0;
            r_a_o     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_load_wr) begin
                case (load_sel_i)
                    SEL_A:   r_cnt_a <= r_cnt_a + 1'b1;
                    SEL_B:   r_cnt_b <= r_cnt_b + 1'b1;
                    default: r_cnt_p <= r_cnt_p + 1'b1;
                endcase
            end
            if (w_start) begin
                r_cnt_a   <= '0;
                r_cnt_b   <= '0;
                r_cnt_p   <= '0;
                r_res_cnt <= '0;
                r_b_idx   <= '0;
                r_p_idx   <= '0;
                r_grp     <= '0;
                r_a_o     <= w_a_grp;
            end
            if (w_run && a_shift_i) begin
                r_grp <= w_grp_nxt;
                r_a_o <= w_a_grp;
            end
            if (w_run && b_fetch_i)
                r_b_idx <= w_b_idx_nxt;
            if (w_run && p_fetch_i)
                r_p_idx <= w_p_idx_nxt;
            if (w_push_ok)
                r_res_cnt <= r_res_cnt + 1'b1;
            if (w_done)
                r_rd_idx <= '0;
            else if (w_rd_hs)
                r_rd_idx <= w_rd_idx_nxt;
            if (w_go_ok)
                r_err <= 1'b0;
            if (w_load_bad || w_push_bad || w_short)
                r_err <= 1'b1;
        end
    end

    assign a_o   = r_a_o;
    assign err_o = r_err;

`ifdef FIOS_OPSRV_PERF_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            r_cycles <= '0;
        else if (w_start)
            r_cycles <= '0;
        else if (w_run && (r_cycles != 32'hFFFF_FFFF))
            r_cycles <= r_cycles + 32'd1;
    end

    assign cycles_o = r_cycles;
`endif

endmodule
